// File: rtl/asin_search.sv
// asin_search: successive-approximation arcsine over a quarter-wave sine ROM.
// Takes a signed Q8.8 sine sample and returns the principal-range angle
// index (quadrants I and IV) on a valid/ready handshake, one ROM probe per
// clock. Define ASIN_ROUND_NEAREST_EN to add a ROUND cycle that picks the
// nearest table entry instead of the floor.
// The ROM contents are generated at elaboration and match ROM_FILE's image:
// entry i = round(2^W * sin(i*90deg/DEPTH)), saturated to 2^W-1.

module rom_async #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data
);
  // Taylor series keeps the table a pure constant function of its index.
  function automatic int sine_entry(input int i);
    real x, term, s, v;
    int  r;
    x    = real'(i) * 3.14159265358979 / (2.0 * real'(DEPTH));
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      s    = s + term;
    end
    v = s * real'(1 << WIDTH);
    r = $rtoi(v + 0.5);
    if (r > (1 << WIDTH) - 1) r = (1 << WIDTH) - 1;
    return r;
  endfunction

  logic [WIDTH-1:0] rom_mem [DEPTH];

  // NOTE: the table is constant wiring, so it has no reset and no clock.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign rom_mem[i] = WIDTH'(sine_entry(i));
  end

  assign data = rom_mem[addr];
endmodule

module asin_search #(
  parameter int ROM_DEPTH = 64,
  parameter int ROM_WIDTH = 8,
  parameter     ROM_FILE  = "sine_table_64x8.mem",
  parameter int ADDRW     = $clog2(4 * ROM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*ROM_WIDTH-1:0] sine_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDRW-1:0]       angle_id,
  output logic                   range_err
);
  localparam int TABW = $clog2(ROM_DEPTH);
  localparam int MAGW = ROM_WIDTH + 1;
  localparam int INW  = 2 * ROM_WIDTH;
  localparam logic [MAGW-1:0] FULL = {1'b1, {ROM_WIDTH{1'b0}}};

`ifdef ASIN_ROUND_NEAREST_EN
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ROUND, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;
`endif

  state_t            state, state_nx;
  logic              sign_q;
  logic [MAGW-1:0]   mag_q;
  logic [TABW:0]     k_q;
  logic [TABW-1:0]   bit_q;
  logic [ADDRW-1:0]  angle_q;
  logic              range_err_q;

  logic [TABW-1:0]   trial;
  logic [TABW-1:0]   rom_addr;
  logic [ROM_WIDTH-1:0] tab_data;
  logic              hit;
  logic [TABW:0]     k_search_nx;
  logic [TABW:0]     k_final;
  logic [INW:0]      abs_in;
  logic              over;
  logic [MAGW-1:0]   mag_in;

  // Negative full-scale 0x8000 negates cleanly in INW+1 bits and then clamps.
  function automatic logic [ADDRW-1:0] map_angle(input logic s, input logic [TABW:0] k);
    if (s && (k != '0)) return ADDRW'(4 * ROM_DEPTH - int'(k));
    return ADDRW'(k);
  endfunction

  rom_async #(.DEPTH(ROM_DEPTH), .WIDTH(ROM_WIDTH)) u_rom (
    .addr (rom_addr),
    .data (tab_data)
  );

  assign abs_in      = sine_in[INW-1] ? ((INW+1)'(0) - {1'b1, sine_in}) : {1'b0, sine_in};
  assign over        = abs_in > (INW+1)'(FULL);
  assign mag_in      = over ? FULL : abs_in[MAGW-1:0];
  assign trial       = k_q[TABW-1:0] | (TABW'(1) << bit_q);
  assign hit         = {1'b0, tab_data} <= mag_q;
  assign k_search_nx = hit ? {1'b0, trial} : k_q;
  assign k_final     = (mag_q == FULL) ? (TABW+1)'(ROM_DEPTH) : k_search_nx;

`ifdef ASIN_ROUND_NEAREST_EN
  logic [MAGW-1:0] ek_q;
  logic [MAGW-1:0] e1;
  logic            round_up;

  assign e1       = (k_q == (TABW+1)'(ROM_DEPTH - 1)) ? FULL : {1'b0, tab_data};
  assign round_up = (k_q != (TABW+1)'(ROM_DEPTH)) && ((e1 - mag_q) < (mag_q - ek_q));
  assign rom_addr = (state == S_ROUND) ? (k_q[TABW-1:0] + TABW'(1)) : trial;

  // Track the table value of the current k so ROUND needs only one probe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ek_q <= '0;
    end else if (state == S_IDLE && in_valid) begin
      ek_q <= '0;
    end else if (state == S_SEARCH && hit) begin
      ek_q <= {1'b0, tab_data};
    end
  end
`else
  assign rom_addr = trial;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: defaulting state_nx first keeps this block free of inferred latches.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (in_valid) state_nx = S_SEARCH;
`ifdef ASIN_ROUND_NEAREST_EN
      S_SEARCH: if (bit_q == '0) state_nx = S_ROUND;
      S_ROUND:  state_nx = S_DONE;
`else
      S_SEARCH: if (bit_q == '0) state_nx = S_DONE;
`endif
      S_DONE:   if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Search datapath: capture, one bit decision per cycle, result mapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q      <= 1'b0;
      mag_q       <= '0;
      k_q         <= '0;
      bit_q       <= TABW'(TABW - 1);
      angle_q     <= '0;
      range_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          sign_q      <= sine_in[INW-1];
          mag_q       <= mag_in;
          range_err_q <= over;
          k_q         <= '0;
          bit_q       <= TABW'(TABW - 1);
        end
        S_SEARCH: begin
          bit_q <= bit_q - TABW'(1);
          if (bit_q == '0) begin
            k_q     <= k_final;
`ifndef ASIN_ROUND_NEAREST_EN
            angle_q <= map_angle(sign_q, k_final);
`endif
          end else begin
            k_q <= k_search_nx;
          end
        end
`ifdef ASIN_ROUND_NEAREST_EN
        S_ROUND: begin
          k_q     <= round_up ? k_q + (TABW+1)'(1) : k_q;
          angle_q <= map_angle(sign_q, round_up ? k_q + (TABW+1)'(1) : k_q);
        end
`endif
        default: ;
      endcase
    end
  end

  assign angle_id  = angle_q;
  assign range_err = range_err_q;
endmodule

// File: tb/tb_asin_search.sv
// Bench for asin_search: directed test-plan vectors, randomized samples
// against an arithmetic arcsine model, output hold, and mid-search reset.
`timescale 1ns/1ps
module tb_asin_search;
  localparam int DEPTH = 64;
  localparam int WIDTH = 8;
`ifdef ASIN_ROUND_NEAREST_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sine_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  angle_id;
  logic        range_err;

  int total = 0;
  int bad   = 0;
  int tab [DEPTH];

  always #5 clk = ~clk;

  asin_search dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sine_in   (sine_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle_id  (angle_id),
    .range_err (range_err)
  );

  // Reference: the angle whose quantised sine best matches the sample.
  task automatic model(input logic [15:0] s, output logic [7:0] a, output logic e);
    int v, m, k;
    bit neg;
    v   = int'($signed(s));
    neg = v < 0;
    m   = neg ? -v : v;
    e   = m > 256;
    if (m > 256) m = 256;
    k = 0;
    if (m == 256) k = DEPTH;
    else for (int i = 0; i < DEPTH; i++) if (tab[i] <= m) k = i;
`ifdef ASIN_ROUND_NEAREST_EN
    if (k < DEPTH) begin
      int e1;
      e1 = (k == DEPTH - 1) ? 256 : tab[k + 1];
      if ((e1 - m) < (m - tab[k])) k = k + 1;
    end
`endif
    a = (neg && k > 0) ? 8'(256 - k) : 8'(k);
  endtask

  // Drive one sample, wait for the result, leave it un-taken.
  task automatic send_wait(input logic [15:0] s, output int lat);
    sine_in  = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sine_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, angle_id, range_err} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset: rdy=%b vld=%b ang=%0d err=%b, want 1 0 0 0", in_ready, out_valid, angle_id, range_err);
    end
  endtask

  task automatic test_directed;
    logic [15:0] vec [7] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0080, 16'hFF80, 16'h0200, 16'h8000};
    logic [7:0]  a_exp [7] = '{8'd0, 8'd64, 8'd192, 8'd21, 8'd235, 8'd64, 8'd192};
    logic        e_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 7; i++) begin
      send_wait(vec[i], lat);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL latency %h: got %0d want %0d", vec[i], lat, LAT);
      end
      total++;
      if ({angle_id, range_err} !== {a_exp[i], e_exp[i]}) begin
        bad++;
        $display("FAIL directed %h: ang=%0d err=%b want ang=%0d err=%b", vec[i], angle_id, range_err, a_exp[i], e_exp[i]);
      end
      take();
    end
  endtask

  task automatic test_random;
    logic [15:0] s;
    logic [7:0]  a;
    logic        e;
    int lat;
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) s = 16'($urandom);
      else            s = 16'(int'($urandom_range(0, 600)) - 300);
      model(s, a, e);
      send_wait(s, lat);
      total++;
      if (lat !== LAT || angle_id !== a || range_err !== e) begin
        bad++;
        $display("FAIL random %h: ang=%0d err=%b lat=%0d want ang=%0d err=%b lat=%0d", s, angle_id, range_err, lat, a, e, LAT);
      end
      take();
    end
  endtask

  task automatic test_hold;
    int lat;
    int errs;
    send_wait(16'h0080, lat);
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin sine_in = 16'h0100; in_valid = 1'b1; end
      @(negedge clk);
      in_valid = 1'b0;
      if (angle_id !== 8'd21 || out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL hold: %0d unstable cycles, ang=%0d want 21", errs, angle_id);
    end
    take();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL ignored_in: %0d cycles with out_valid, want 0", errs);
    end
  endtask

  task automatic test_reset_mid_search;
    int lat;
    int errs;
    sine_in  = 16'h0080;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL abort_result: %0d cycles with out_valid, want 0", errs);
    end
    send_wait(16'h0100, lat);
    total++;
    if (lat !== LAT || angle_id !== 8'd64 || range_err !== 1'b0) begin
      bad++;
      $display("FAIL after_abort: ang=%0d err=%b lat=%0d want 64 0 %0d", angle_id, range_err, lat, LAT);
    end
    take();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      int r;
      r = $rtoi(256.0 * $sin(real'(i) * 3.14159265358979 / 128.0) + 0.5);
      tab[i] = (r > 255) ? 255 : r;
    end
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid_search();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
